mmio_controller: RTL and testbench
==================================

// Module: mmio_controller
// PURPOSE
//  Memory-mapped I/O controller between the processor data port and the data RAM.
//  Decodes address_dmem into RAM space (< IO_BASE) or I/O registers: switches, LEDs,
//  cycle counter/compare timer and a debounced button with status flags.
//  Returns read data with the same 1-cycle latency as RAM. Gates RAM writes so I/O
//  stores never alias into RAM.
// PARAMETERS
//  IO_BASE        32'd4096   first I/O word address; I/O window is IO_BASE..IO_BASE+15
//  DEBOUNCE_CYC   20'd290000 cycles the synced button must be stable before it is accepted (~10 ms)
//  SW_W           16         switch/LED width
// PORTS
//  clock          in   1     system clock; all state updates on posedge
//  reset          in   1     asynchronous, active-high; clears all state
//  address_dmem   in   32    processor data address (word)
//  data           in   32    processor store data
//  wren           in   1     processor store enable
//  q_ram          in   32    RAM read data (valid 1 cycle after address)
//  ram_wren       out  1     RAM write enable = wren & ~io_sel (combinational)
//  q_dmem         out  32    read data to processor
//  SW             in   SW_W  raw switches (asynchronous)
//  btn            in   1     raw push button (asynchronous, bouncy)
//  LED            out  SW_W  LED register
// BEHAVIOUR
//  - io_sel = (address_dmem >= IO_BASE) && (address_dmem < IO_BASE+16); combinational.
//  - Register map (offset from IO_BASE): 0 SW (RO, zero-extended); 1 LED (RW, low SW_W bits);
//    2 CYCLE (RW, free-running 32b up-counter); 3 CMP (RW); 4 STATUS (bit0 match, bit1 btn
//    level, bit2 btn press; bits0,2 write-1-to-clear); 5..15 reserved: read 0, writes ignored.
//  - Read latency 1 cycle: on posedge, register io_sel_q and io_rdata_q (from current address);
//    q_dmem = io_sel_q ? io_rdata_q : q_ram. Writes take effect on the same posedge.
//  - SW: two-flop synchronizer, then read value. btn: two-flop synchronizer into debouncer.
//  - CYCLE increments every cycle, wraps 32'hFFFF_FFFF -> 0. A CPU write loads data and
//    suppresses that cycle's increment (next cycle counts from loaded value).
//  - Match: when CYCLE == CMP, STATUS.match sets next edge. Sticky until W1C.
//  - Debouncer FSM: STABLE -> (synced != level) -> COUNT; COUNT: cnt++ while synced != level,
//    return to STABLE (cnt=0) if synced == level; at cnt == DEBOUNCE_CYC-1 update level,
//    go STABLE. Rising level change sets STATUS.press (sticky, W1C).
//  - Simultaneous set and W1C of the same flag in one cycle: set wins.
//  - Reset: LED=0, CYCLE=0, CMP=32'hFFFF_FFFF, STATUS=0, sync flops=0, debouncer STABLE/0,
//    io_sel_q=0, io_rdata_q=0. q_dmem follows q_ram during and after reset until an I/O read.
//  - Reset asserted mid-debounce or mid-read aborts cleanly; no partial state survives.
//  - wren to I/O addresses never asserts ram_wren; RAM addresses pass wren unchanged.
// STRUCTURE
//  - Package mmio_pkg: IO_BASE default, register offsets (OFF_SW..OFF_STATUS), STATUS bit indices.
//  - Sub-module btn_debouncer (clock, reset, raw, level, rise): synchronizer + FSM + counter.
//  - Top holds decode, register file, counter/compare, read pipeline.
// TESTING
//  1. Reset, SW=16'hA5A5, wait 3 cycles, read 4096 -> q_dmem=32'h0000A5A5 one cycle later.
//  2. Store 32'h1234_BEEF to 4097 -> LED=16'hBEEF next edge, ram_wren=0; read 0 still returns prior RAM word.
//  3. Store 32'hFFFF_FFFE to 4098, CMP=32'h0000_0001 -> CYCLE wraps to 0, STATUS.match=1 at value 1; W1C clears.
//  4. btn bounces 5 times within 100 cycles then held high (DEBOUNCE_CYC=16 in bench) ->
//     level rises once, exactly 16+2 cycles after last edge; STATUS.press=1.
//  5. W1C of STATUS.match in same cycle CYCLE==CMP -> match remains 1.
//  6. Reset asserted mid-count and mid-I/O-read -> all outputs at reset values immediately;
//     read of 4101 returns 0; store to 4101 changes nothing.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped I/O controller: window base,
// register offsets, STATUS bit positions and the debouncer state type.
package mmio_pkg;

  localparam logic [31:0] IO_BASE_DEF = 32'd4096;
  localparam logic [31:0] IO_SPAN     = 32'd16;

  localparam logic [3:0] OFF_SW     = 4'd0;
  localparam logic [3:0] OFF_LED    = 4'd1;
  localparam logic [3:0] OFF_CYCLE  = 4'd2;
  localparam logic [3:0] OFF_CMP    = 4'd3;
  localparam logic [3:0] OFF_STATUS = 4'd4;

  localparam int ST_MATCH = 0;
  localparam int ST_LEVEL = 1;
  localparam int ST_PRESS = 2;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_COUNT  = 1'b1
  } db_state_e;

  // True when addr falls inside the 16-word I/O window starting at base.
  // The upper bound is formed in 33 bits so a window near the top of the
  // address space cannot wrap.
  function automatic logic in_io_window(input logic [31:0] addr,
                                        input logic [31:0] base);
    logic [32:0] lim;
    lim = {1'b0, base} + {1'b0, IO_SPAN};
    return (addr >= base) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Push-button conditioner: two-flop synchronizer followed by a stability
// counter. The accepted level only changes after the synchronized input has
// differed from it for DEBOUNCE_CYC consecutive cycles.
module btn_debouncer
  import mmio_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd290000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic        s1_q;
  logic        s2_q;
  logic        level_q;
  logic [19:0] cnt_q;
  db_state_e   state_q;
  logic        accept;

  // The cycle that detects the difference counts as the first stable
  // cycle, so acceptance happens on the DEBOUNCE_CYC-th differing cycle.
  assign accept = (state_q == DB_COUNT) && (s2_q != level_q) &&
                  (cnt_q == DEBOUNCE_CYC - 20'd1);

  // Synchronizer, debounce FSM and stability counter in one state machine.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      case (state_q)
        DB_STABLE: begin
          if (s2_q != level_q) begin
            state_q <= DB_COUNT;
            cnt_q   <= 20'd1;
          end
        end
        DB_COUNT: begin
          if (s2_q == level_q) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else if (accept) begin
            level_q <= s2_q;
            state_q <= DB_STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        default: begin
          state_q <= DB_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level = level_q;
  // One-cycle strobe aligned with the edge that raises the accepted level.
  assign rise  = accept & s2_q;

endmodule

// File: rtl/mmio_controller.sv
// Memory-mapped I/O controller sitting between the processor data port and
// the data RAM. Decodes a 16-word I/O window, holds the switch/LED/timer/
// button registers and returns read data with the same 1-cycle latency as
// the RAM. Stores into the I/O window never reach the RAM.
module mmio_controller
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE      = IO_BASE_DEF,
  parameter logic [19:0] DEBOUNCE_CYC = 20'd290000,
  parameter int          SW_W         = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     address_dmem,
  input  logic [31:0]     data,
  input  logic            wren,
  input  logic [31:0]     q_ram,
  output logic            ram_wren,
  output logic [31:0]     q_dmem,
  input  logic [SW_W-1:0] SW,
  input  logic            btn,
  output logic [SW_W-1:0] LED
);

  logic            io_sel;
  logic            io_wr;
  logic [3:0]      io_off;
  logic            wr_led;
  logic            wr_cycle;
  logic            wr_cmp;
  logic            wr_status;

  logic [SW_W-1:0] sw_s1_q;
  logic [SW_W-1:0] sw_s2_q;
  logic [SW_W-1:0] led_q;
  logic [SW_W-1:0] led_d;
  logic [31:0]     cycle_q;
  logic [31:0]     cycle_d;
  logic [31:0]     cmp_q;
  logic [31:0]     cmp_d;
  logic            match_q;
  logic            match_d;
  logic            press_q;
  logic            press_d;
  logic            io_sel_q;
  logic [31:0]     io_rdata_q;
  logic [31:0]     io_rdata_d;

  logic            btn_level;
  logic            btn_rise;

  // Only the low nibble of (address - base) is needed inside the window.
  assign io_sel    = in_io_window(address_dmem, IO_BASE);
  assign io_off    = address_dmem[3:0] - IO_BASE[3:0];
  assign io_wr     = wren & io_sel;
  assign ram_wren  = wren & ~io_sel;

  assign wr_led    = io_wr && (io_off == OFF_LED);
  assign wr_cycle  = io_wr && (io_off == OFF_CYCLE);
  assign wr_cmp    = io_wr && (io_off == OFF_CMP);
  assign wr_status = io_wr && (io_off == OFF_STATUS);

  btn_debouncer #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .clock (clock),
    .reset (reset),
    .raw   (btn),
    .level (btn_level),
    .rise  (btn_rise)
  );

  // Next-state for the register file; sticky flags let a set beat a W1C.
  always_comb begin
    led_d   = wr_led ? data[SW_W-1:0] : led_q;
    cycle_d = wr_cycle ? data : cycle_q + 32'd1;
    cmp_d   = wr_cmp ? data : cmp_q;

    match_d = match_q;
    if (wr_status && data[ST_MATCH]) match_d = 1'b0;
    if (cycle_q == cmp_q)            match_d = 1'b1;

    press_d = press_q;
    if (wr_status && data[ST_PRESS]) press_d = 1'b0;
    if (btn_rise)                    press_d = 1'b1;
  end

  // Read mux over the current register values; reserved offsets read 0.
  always_comb begin
    io_rdata_d = '0;
    if (io_sel) begin
      case (io_off)
        OFF_SW:    io_rdata_d = 32'(sw_s2_q);
        OFF_LED:   io_rdata_d = 32'(led_q);
        OFF_CYCLE: io_rdata_d = cycle_q;
        OFF_CMP:   io_rdata_d = cmp_q;
        OFF_STATUS: begin
          io_rdata_d[ST_MATCH] = match_q;
          io_rdata_d[ST_LEVEL] = btn_level;
          io_rdata_d[ST_PRESS] = press_q;
        end
        default:   io_rdata_d = '0;
      endcase
    end
  end

  // Register file, switch synchronizer and read-return pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      led_q      <= '0;
      cycle_q    <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
      press_q    <= 1'b0;
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      sw_s1_q    <= SW;
      sw_s2_q    <= sw_s1_q;
      led_q      <= led_d;
      cycle_q    <= cycle_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      press_q    <= press_d;
      io_sel_q   <= io_sel;
      io_rdata_q <= io_rdata_d;
    end
  end

  assign q_dmem = io_sel_q ? io_rdata_q : q_ram;
  assign LED    = led_q;

endmodule

// File: tb/tb_mmio_controller.sv
// Directed bench for mmio_controller: a table of single-cycle bus
// transactions plus hand-written sequences for the timer, button and reset.
module tb_mmio_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_ram;
  logic        ram_wren;
  logic [31:0] q_dmem;
  logic [15:0] SW;
  logic        btn;
  logic [15:0] LED;

  int checks = 0;
  int errors = 0;

  mmio_controller #(
    .IO_BASE      (32'd4096),
    .DEBOUNCE_CYC (20'd16),
    .SW_W         (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_ram        (q_ram),
    .ram_wren     (ram_wren),
    .q_dmem       (q_dmem),
    .SW           (SW),
    .btn          (btn),
    .LED          (LED)
  );

  always #5 clock = ~clock;

  // Small synchronous RAM: unwritten words read as C0DE00xx.
  bit [31:0] mem [256];
  bit        written [256];
  always @(posedge clock) begin
    if (ram_wren) begin
      mem[address_dmem[7:0]]     <= data;
      written[address_dmem[7:0]] <= 1'b1;
    end
    q_ram <= written[address_dmem[7:0]] ? mem[address_dmem[7:0]]
                                        : (32'hC0DE_0000 | {24'd0, address_dmem[7:0]});
  end

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        exp_ramwren;
    logic [31:0] exp_q;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w);
    address_dmem = a;
    data         = d;
    wren         = w;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    SW    = 16'hA5A5;
    btn   = 1'b0;
    bus(32'd0, 32'd0, 1'b0);

    // Reset state: q_dmem follows RAM, LED cleared, ram_wren gated by decode.
    tick();
    check("rst_q_follows_ram", q_dmem, 32'hC0DE_0000);
    check("rst_led", {16'd0, LED}, 32'd0);
    bus(32'd4097, 32'h1111_1111, 1'b1);
    #1 check("rst_ramwren_io", {31'd0, ram_wren}, 32'd0);
    bus(32'd5, 32'h2222_2222, 1'b1);
    #1 check("rst_ramwren_ram", {31'd0, ram_wren}, 32'd1);
    bus(32'd0, 32'd0, 1'b0);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();

    vq.push_back('{"rd_sw",        32'd4096, 32'h0,         1'b0, 1'b0, 32'h0000_A5A5, 16'h0000});
    vq.push_back('{"wr_led",       32'd4097, 32'h1234_BEEF, 1'b1, 1'b0, 32'h0000_0000, 16'hBEEF});
    vq.push_back('{"rd_ram0",      32'd0,    32'h0,         1'b0, 1'b0, 32'hC0DE_0000, 16'hBEEF});
    vq.push_back('{"rd_ram1_alias",32'd1,    32'h0,         1'b0, 1'b0, 32'hC0DE_0001, 16'hBEEF});
    vq.push_back('{"rd_led",       32'd4097, 32'h0,         1'b0, 1'b0, 32'h0000_BEEF, 16'hBEEF});
    vq.push_back('{"wr_ram1",      32'd1,    32'h0000_0055, 1'b1, 1'b1, 32'hC0DE_0001, 16'hBEEF});
    vq.push_back('{"rd_ram1",      32'd1,    32'h0,         1'b0, 1'b0, 32'h0000_0055, 16'hBEEF});
    vq.push_back('{"wr_rsvd5",     32'd4101, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 16'hBEEF});
    vq.push_back('{"rd_rsvd5",     32'd4101, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 16'hBEEF});
    vq.push_back('{"rd_rsvd15",    32'd4111, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 16'hBEEF});
    vq.push_back('{"wr_above_win", 32'd4112, 32'h0000_0077, 1'b1, 1'b1, 32'hC0DE_0010, 16'hBEEF});
    vq.push_back('{"rd_above_win", 32'd4112, 32'h0,         1'b0, 1'b0, 32'h0000_0077, 16'hBEEF});
    vq.push_back('{"wr_below_win", 32'd4095, 32'h0000_0099, 1'b1, 1'b1, 32'hC0DE_00FF, 16'hBEEF});
    vq.push_back('{"rd_below_win", 32'd4095, 32'h0,         1'b0, 1'b0, 32'h0000_0099, 16'hBEEF});
    vq.push_back('{"rd_cmp_rst",   32'd4099, 32'h0,         1'b0, 1'b0, 32'hFFFF_FFFF, 16'hBEEF});
    vq.push_back('{"rd_status0",   32'd4100, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 16'hBEEF});
    vq.push_back('{"wr_sw_ro",     32'd4096, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_A5A5, 16'hBEEF});
    vq.push_back('{"rd_sw_again",  32'd4096, 32'h0,         1'b0, 1'b0, 32'h0000_A5A5, 16'hBEEF});

    foreach (vq[i]) begin
      bus(vq[i].addr, vq[i].wdata, vq[i].wr);
      #1 check({vq[i].name, "_ramwren"}, {31'd0, ram_wren}, {31'd0, vq[i].exp_ramwren});
      tick();
      check({vq[i].name, "_q"}, q_dmem, vq[i].exp_q);
      check({vq[i].name, "_led"}, {16'd0, LED}, {16'd0, vq[i].exp_led});
    end

    // Timer wrap and compare match, then W1C.
    bus(32'd4099, 32'h0000_0001, 1'b1); tick();
    bus(32'd4098, 32'hFFFF_FFFE, 1'b1); tick();
    bus(32'd4098, 32'h0, 1'b0);
    tick(); check("cyc_loaded", q_dmem, 32'hFFFF_FFFE);
    tick(); check("cyc_max", q_dmem, 32'hFFFF_FFFF);
    tick(); check("cyc_wrap", q_dmem, 32'h0000_0000);
    bus(32'd4100, 32'h0, 1'b0);
    tick(); check("match_not_yet", q_dmem, 32'h0000_0000);
    tick(); check("match_set", q_dmem, 32'h0000_0001);
    bus(32'd4100, 32'h0000_0001, 1'b1); tick();
    bus(32'd4100, 32'h0, 1'b0);
    tick(); check("match_w1c", q_dmem, 32'h0000_0000);

    // W1C landing on the same edge the match sets: set wins.
    bus(32'd4099, 32'h1000_0003, 1'b1); tick();
    bus(32'd4098, 32'h1000_0000, 1'b1); tick();
    bus(32'd0, 32'h0, 1'b0);
    tick(); tick(); tick();
    bus(32'd4100, 32'h0000_0001, 1'b1); tick();
    bus(32'd4100, 32'h0, 1'b0);
    tick(); check("match_set_beats_w1c", q_dmem, 32'h0000_0001);
    bus(32'd4100, 32'h0000_0001, 1'b1); tick();
    bus(32'd4100, 32'h0, 1'b0);
    tick(); check("match_w1c_again", q_dmem, 32'h0000_0000);

    // Bouncy button: short pulses rejected, a held press accepted 16+2 cycles later.
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1;
      for (int k = 0; k < 7; k++) tick();
      btn = 1'b0;
      for (int k = 0; k < 7; k++) tick();
    end
    check("bounce_rejected", q_dmem, 32'h0000_0000);
    btn = 1'b1;
    for (int k = 0; k < 18; k++) tick();
    check("btn_level_edge18_pre", q_dmem, 32'h0000_0000);
    tick();
    check("btn_level_press", q_dmem, 32'h0000_0006);
    bus(32'd4100, 32'h0000_0004, 1'b1); tick();
    bus(32'd4100, 32'h0, 1'b0);
    tick(); check("press_w1c", q_dmem, 32'h0000_0002);
    btn = 1'b0;
    for (int k = 0; k < 22; k++) tick();
    check("release_no_press", q_dmem, 32'h0000_0000);

    // Reset in the middle of a debounce count and an I/O read.
    btn = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    bus(32'd4097, 32'h0, 1'b0);
    tick(); check("pre_rst_led_read", q_dmem, 32'h0000_BEEF);
    reset = 1'b1;
    #1;
    check("async_rst_q", q_dmem, 32'h0000_0055);
    check("async_rst_led", {16'd0, LED}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1 check("post_rst_q", q_dmem, 32'h0000_0055);
    bus(32'd4098, 32'h0, 1'b0);
    tick(); check("post_rst_cycle0", q_dmem, 32'h0000_0000);
    tick(); check("post_rst_cycle1", q_dmem, 32'h0000_0001);
    bus(32'd4100, 32'h0, 1'b0);
    for (int k = 0; k < 16; k++) tick();
    check("post_rst_no_partial", q_dmem, 32'h0000_0000);
    tick(); check("post_rst_press", q_dmem, 32'h0000_0006);
    bus(32'd4099, 32'h0, 1'b0);
    tick(); check("post_rst_cmp", q_dmem, 32'hFFFF_FFFF);
    bus(32'd4101, 32'h0, 1'b0);
    tick(); check("post_rst_rsvd", q_dmem, 32'h0000_0000);
    bus(32'd4101, 32'hFFFF_FFFF, 1'b1);
    #1 check("rsvd_wr_ramwren", {31'd0, ram_wren}, 32'd0);
    tick();
    bus(32'd4097, 32'h0, 1'b0);
    tick(); check("rsvd_wr_led_kept", q_dmem, 32'h0000_0000);
    check("rsvd_wr_led_port", {16'd0, LED}, 32'd0);
    bus(32'd4100, 32'h0, 1'b0);
    tick(); check("rsvd_wr_status_kept", q_dmem, 32'h0000_0006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
